// File: rtl/key_filter_pkg.sv
// key_filter_pkg: shared key definitions for the push-button filter.
//   - FSM state encoding (2-bit, fixed values so other blocks can decode it)
//   - default counter width and 50 MHz count values (20 ms debounce, 1 s hold)
package key_filter_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_FILT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_FILT = 2'd3
  } key_fsm_e;

  localparam int DEF_CNT_W        = 26;
  localparam int DEF_DEBOUNCE_CNT = 1_000_000;   // 20 ms at 50 MHz
  localparam int DEF_LONG_CNT     = 50_000_000;  // 1 s at 50 MHz

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for an asynchronous single-bit input.
//   clk   - destination clock
//   rst   - synchronous active-high reset, loads RST_VAL into both flops
//   d     - asynchronous input
//   q     - synchronised output (two cycles of latency)
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic sync1_q, sync2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= RST_VAL;
      sync2_q <= RST_VAL;
    end else begin
      sync1_q <= d;
      sync2_q <= sync1_q;
    end
  end

  assign q = sync2_q;

endmodule

// File: rtl/key_filter.sv
// key_filter: debounces one active-low push-button into clean events.
//   sys_clk      - system clock (50 MHz nominal)
//   sys_rst      - synchronous active-high reset
//   key_in       - raw button pin, asynchronous, 0 = pressed
//   key_state    - debounced level, 1 = pressed
//   key_flag     - one-cycle pulse on accepted press
//   release_flag - one-cycle pulse on accepted release
//   long_flag    - one-cycle pulse once per press when the hold reaches LONG_CNT
module key_filter
  import key_filter_pkg::*;
#(
  parameter int CNT_W        = DEF_CNT_W,
  parameter int DEBOUNCE_CNT = DEF_DEBOUNCE_CNT,
  parameter int LONG_CNT     = DEF_LONG_CNT
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic key_in,
  output logic key_state,
  output logic key_flag,
  output logic release_flag,
  output logic long_flag
);

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CNT - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CNT - 1);

  logic key_sync;
  logic pressed;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk (sys_clk),
    .rst (sys_rst),
    .d   (key_in),
    .q   (key_sync)
  );

  assign pressed = ~key_sync;

  key_fsm_e         state_q, state_d;
  logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             long_done_q, long_done_d;
  logic             key_state_q, key_state_d;
  logic             key_flag_q, key_flag_d;
  logic             release_flag_q, release_flag_d;
  logic             long_flag_q, long_flag_d;

  always_comb begin
    state_d        = state_q;
    deb_cnt_d      = deb_cnt_q;
    hold_cnt_d     = hold_cnt_q;
    long_done_d    = long_done_q;
    key_state_d    = key_state_q;
    key_flag_d     = 1'b0;
    release_flag_d = 1'b0;
    long_flag_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (pressed) begin
          state_d   = PRESS_FILT;
          deb_cnt_d = '0;
        end
      end
      PRESS_FILT: begin
        if (!pressed) begin
          state_d   = IDLE;
          deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_LAST) begin
          state_d     = HELD;
          deb_cnt_d   = '0;
          key_flag_d  = 1'b1;
          key_state_d = 1'b1;
          hold_cnt_d  = '0;
          long_done_d = 1'b0;
        end else begin
          deb_cnt_d = deb_cnt_q + CNT_W'(1);
        end
      end
      HELD: begin
        // A release candidate wins over a long-press on the same cycle;
        // if the release is a glitch the long press still fires later.
        if (!pressed) begin
          state_d   = RELEASE_FILT;
          deb_cnt_d = '0;
        end else if (!long_done_q) begin
          if (hold_cnt_q == LONG_LAST) begin
            long_flag_d = 1'b1;
            long_done_d = 1'b1;   // hold_cnt stays frozen from here on
          end else begin
            hold_cnt_d = hold_cnt_q + CNT_W'(1);
          end
        end
      end
      RELEASE_FILT: begin
        // Bounce back into HELD keeps hold progress and long_done so a
        // glitchy hold neither re-fires nor restarts the long press.
        if (pressed) begin
          state_d   = HELD;
          deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_LAST) begin
          state_d        = IDLE;
          deb_cnt_d      = '0;
          key_state_d    = 1'b0;
          release_flag_d = 1'b1;
        end else begin
          deb_cnt_d = deb_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d   = IDLE;
        deb_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q        <= IDLE;
      deb_cnt_q      <= '0;
      hold_cnt_q     <= '0;
      long_done_q    <= 1'b0;
      key_state_q    <= 1'b0;
      key_flag_q     <= 1'b0;
      release_flag_q <= 1'b0;
      long_flag_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      deb_cnt_q      <= deb_cnt_d;
      hold_cnt_q     <= hold_cnt_d;
      long_done_q    <= long_done_d;
      key_state_q    <= key_state_d;
      key_flag_q     <= key_flag_d;
      release_flag_q <= release_flag_d;
      long_flag_q    <= long_flag_d;
    end
  end

  assign key_state    = key_state_q;
  assign key_flag     = key_flag_q;
  assign release_flag = release_flag_q;
  assign long_flag    = long_flag_q;

endmodule

// File: tb/tb_key_filter.sv
// tb_key_filter: directed self-checking bench for key_filter with
// DEBOUNCE_CNT=10, LONG_CNT=50. A segment table checks flag counts per
// input phase; hand sequences check exact latencies, glitches and resets.
module tb_key_filter;

  localparam int CNT_W = 26;
  localparam int DEB   = 10;
  localparam int LNG   = 50;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  logic key_in  = 1'b1;
  logic key_state, key_flag, release_flag, long_flag;

  key_filter #(.CNT_W(CNT_W), .DEBOUNCE_CNT(DEB), .LONG_CNT(LNG)) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .key_in       (key_in),
    .key_state    (key_state),
    .key_flag     (key_flag),
    .release_flag (release_flag),
    .long_flag    (long_flag)
  );

  always #5 sys_clk = ~sys_clk;

  int tests = 0;
  int fails = 0;
  int n_kf, n_rf, n_lf, n_st;
  int n_multi = 0;

  typedef struct {
    logic rst;
    logic key;
    int   ncyc;
    int   kf;
    int   rf;
    int   lf;
    logic st;
  } seg_t;

  seg_t segs[6];

  task automatic tick();
    @(posedge sys_clk);
    #1;
    n_kf += int'(key_flag);
    n_rf += int'(release_flag);
    n_lf += int'(long_flag);
    n_st += int'(key_state);
    if (int'(key_flag) + int'(release_flag) + int'(long_flag) > 1) n_multi++;
  endtask

  task automatic clr();
    n_kf = 0; n_rf = 0; n_lf = 0; n_st = 0;
  endtask

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run(input logic k, input int n);
    key_in = k;
    repeat (n) tick();
  endtask

  // Ticks until the selected flag is seen (0=key, 1=release, 2=long);
  // n = tick index where it appeared, -1 if the bound expired.
  task automatic ticks_to(input int which, input int bound, output int n);
    logic f;
    n = -1;
    for (int i = 1; i <= bound; i++) begin
      tick();
      f = (which == 0) ? key_flag : (which == 1) ? release_flag : long_flag;
      if (f) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    int n;

    //          rst   key   ncyc kf rf lf st
    segs[0] = '{1'b1, 1'b1,   3, 0, 0, 0, 1'b0};  // reset
    segs[1] = '{1'b0, 1'b1, 100, 0, 0, 0, 1'b0};  // idle
    segs[2] = '{1'b0, 1'b0,  30, 1, 0, 0, 1'b1};  // clean press
    segs[3] = '{1'b0, 1'b1,  20, 0, 1, 0, 1'b0};  // release
    segs[4] = '{1'b0, 1'b0, 120, 1, 0, 1, 1'b1};  // long hold
    segs[5] = '{1'b0, 1'b1,  20, 0, 1, 0, 1'b0};  // release after long

    for (int i = 0; i < 6; i++) begin
      clr();
      sys_rst = segs[i].rst;
      run(segs[i].key, segs[i].ncyc);
      check($sformatf("seg%0d key_flag_cnt", i), n_kf, segs[i].kf);
      check($sformatf("seg%0d release_flag_cnt", i), n_rf, segs[i].rf);
      check($sformatf("seg%0d long_flag_cnt", i), n_lf, segs[i].lf);
      check($sformatf("seg%0d key_state", i), int'(key_state), int'(segs[i].st));
      if (!segs[i].key && !segs[i].rst) check($sformatf("seg%0d state_cycles_low", i), n_st == 0 ? 1 : 0, 0);
      else if (segs[i].kf == 0 && segs[i].rf == 0) check($sformatf("seg%0d state_cycles", i), n_st, 0);
    end

    // Bounce: 3-cycle toggles never satisfy a 10-cycle debounce.
    clr();
    for (int b = 0; b < 40; b++) begin
      key_in = ((b / 3) % 2 == 0) ? 1'b0 : 1'b1;
      tick();
    end
    run(1'b1, 20);
    check("bounce flags", n_kf + n_rf + n_lf, 0);
    check("bounce key_state", n_st, 0);

    // Exact press latency: flag in the cycle after edge s+12.
    clr();
    key_in = 1'b0;
    ticks_to(0, 40, n);
    check("press latency", n, DEB + 3);
    check("press key_state", int'(key_state), 1);

    // Long press 50 cycles after key_flag, only once.
    clr();
    ticks_to(2, 80, n);
    check("long latency", n, LNG);
    check("no second key_flag", n_kf, 0);
    run(1'b0, 60);
    check("single long_flag", n_lf, 1);

    // Release glitch while held.
    clr();
    run(1'b1, 5);
    run(1'b0, 30);
    check("glitch release_flag", n_rf, 0);
    check("glitch key_flag", n_kf, 0);
    check("glitch long_flag", n_lf, 0);
    check("glitch key_state cycles", n_st, 35);

    // Exact release latency.
    clr();
    key_in = 1'b1;
    ticks_to(1, 40, n);
    check("release latency", n, DEB + 3);
    check("release key_state", int'(key_state), 0);
    run(1'b1, 5);
    check("single release_flag", n_rf, 1);

    // Reset during PRESS_FILT.
    clr();
    run(1'b0, 6);
    sys_rst = 1'b1;
    tick();
    check("rst pf key_state", int'(key_state), 0);
    check("rst pf flags", n_kf + n_rf + n_lf, 0);
    sys_rst = 1'b0;
    ticks_to(0, 40, n);
    check("rst pf re-press latency", n, DEB + 3);

    // Reset during HELD.
    run(1'b0, 10);
    clr();
    sys_rst = 1'b1;
    tick();
    check("rst held key_state", int'(key_state), 0);
    check("rst held flags", n_kf + n_rf + n_lf, 0);
    sys_rst = 1'b0;
    ticks_to(0, 40, n);
    check("rst held re-press latency", n, DEB + 3);
    check("rst held no release", n_rf, 0);
    run(1'b1, 20);

    check("flag exclusion", n_multi, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
